// File: rtl/display_timings_if.sv
// Timing bundle from the display timing generator to the pixel-drawing logic
// and the TMDS/VGA output stage.
interface display_timings_if #(
    parameter int CORDW = 16
);
    logic                    o_hs;
    logic                    o_vs;
    logic                    o_de;
    logic                    o_frame;
    logic                    o_line;
    logic signed [CORDW-1:0] o_sx;
    logic signed [CORDW-1:0] o_sy;

    modport master (output o_hs, o_vs, o_de, o_frame, o_line, o_sx, o_sy);
    modport slave  (input  o_hs, o_vs, o_de, o_frame, o_line, o_sx, o_sy);
endinterface

// File: rtl/display_timings.sv
// Display timing generator: signed screen coordinates with registered sync,
// data-enable and line/frame strobes. Defaults give 640x480 at 60 Hz.
module display_timings #(
    parameter int CORDW  = 16,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    display_timings_if.master     o_tim
);
    // Blanking sits at negative coordinates so the active area starts at (0,0).
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(0 - (H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(0 - (H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(0 - H_BP);
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(0 - (V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(0 - (V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(0 - V_BP);
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] ZERO   = CORDW'(0);
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);
    localparam logic HS_ON = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (V_POL != 0) ? 1'b1 : 1'b0;

    logic signed [CORDW-1:0] r_x;
    logic signed [CORDW-1:0] r_y;
    logic signed [CORDW-1:0] r_sx;
    logic signed [CORDW-1:0] r_sy;
    logic                    r_hs;
    logic                    r_vs;
    logic                    r_de;
    logic                    r_frame;
    logic                    r_line;

    logic signed [CORDW-1:0] w_nx;
    logic signed [CORDW-1:0] w_ny;
    logic                    w_hs;
    logic                    w_vs;
    logic                    w_de;
    logic                    w_frame;
    logic                    w_line;

    // Next raster position; wraps at end of line and end of frame.
    always_comb begin
        w_nx = r_x + ONE;
        w_ny = r_y;
        if (r_x == H_END) begin
            w_nx = H_STA;
            if (r_y == V_END) begin
                w_ny = V_STA;
            end else begin
                w_ny = r_y + ONE;
            end
        end else begin
            w_nx = r_x + ONE;
            w_ny = r_y;
        end
    end

    // Flags decoded from the next position so they register alongside it.
    always_comb begin
        w_hs    = ((w_nx >= HS_STA) && (w_nx < HS_END)) ? HS_ON : ~HS_ON;
        w_vs    = ((w_ny >= VS_STA) && (w_ny < VS_END)) ? VS_ON : ~VS_ON;
        w_de    = (w_nx >= ZERO) && (w_ny >= ZERO);
        w_line  = (w_nx == H_STA);
        w_frame = (w_nx == H_STA) && (w_ny == V_STA);
    end

    // Counters park at the last pixel in reset so release lands on the frame start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x     <= H_END;
            r_y     <= V_END;
            r_sx    <= H_STA;
            r_sy    <= V_STA;
            r_hs    <= ~HS_ON;
            r_vs    <= ~VS_ON;
            r_de    <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else begin
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_sx    <= w_nx;
            r_sy    <= w_ny;
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_de    <= w_de;
            r_frame <= w_frame;
            r_line  <= w_line;
        end
    end

    assign o_tim.o_sx    = r_sx;
    assign o_tim.o_sy    = r_sy;
    assign o_tim.o_hs    = r_hs;
    assign o_tim.o_vs    = r_vs;
    assign o_tim.o_de    = r_de;
    assign o_tim.o_frame = r_frame;
    assign o_tim.o_line  = r_line;
endmodule

// File: tb/tb_display_timings.sv
// Directed bench: default 640x480 instance plus a tiny 8x5 instance for
// full-frame period, sync and wrap behaviour.
module tb_display_timings;
    typedef logic [36:0] vec_t;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_s;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    display_timings_if #(.CORDW(16)) bus_d ();
    display_timings_if #(.CORDW(16)) bus_s ();

    display_timings u_d (
        .i_clk   (clk),
        .i_rst_n (rst_d),
        .o_tim   (bus_d)
    );

    display_timings #(
        .CORDW(16), .H_RES(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
    ) u_s (
        .i_clk   (clk),
        .i_rst_n (rst_s),
        .o_tim   (bus_s)
    );

    function automatic vec_t mk(input logic signed [15:0] sx, input logic signed [15:0] sy,
                                input logic hs, input logic vs, input logic de,
                                input logic fr, input logic ln);
        return {sx, sy, hs, vs, de, fr, ln};
    endfunction

    function automatic vec_t act_d();
        return {bus_d.o_sx, bus_d.o_sy, bus_d.o_hs, bus_d.o_vs, bus_d.o_de, bus_d.o_frame, bus_d.o_line};
    endfunction

    function automatic vec_t act_s();
        return {bus_s.o_sx, bus_s.o_sy, bus_s.o_hs, bus_s.o_vs, bus_s.o_de, bus_s.o_frame, bus_s.o_line};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b0;
        rst_s = 1'b0;
        repeat (20) tick();
        n_cmp++;
        if (act_d() !== mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_default: got %h want %h", act_d(), mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        n_cmp++;
        if (act_s() !== mk(-16'sd4, -16'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_small: got %h want %h", act_s(), mk(-16'sd4, -16'sd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_release(input string tag);
        rst_d = 1'b1;
        tick();
        n_cmp++;
        if (act_d() !== mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1)) begin
            n_err++;
            $display("FAIL %s_first: got %h want %h", tag, act_d(), mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
        end
        tick();
        n_cmp++;
        if (act_d() !== mk(-16'sd159, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL %s_second: got %h want %h", tag, act_d(), mk(-16'sd159, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_vblank();
        int k = 0;
        int vs_lo = 0;
        int lines = 0;
        while (!(bus_d.o_sx == -16'sd160 && bus_d.o_sy == 16'sd0) && k < 40000) begin
            tick();
            k++;
            if (bus_d.o_vs == 1'b0) vs_lo++;
            if (bus_d.o_line == 1'b1) lines++;
        end
        n_cmp++;
        if (k != 35999) begin
            n_err++;
            $display("FAIL vblank_cycles: got %0d want 35999", k);
        end
        n_cmp++;
        if (vs_lo != 1600) begin
            n_err++;
            $display("FAIL vsync_width: got %0d want 1600", vs_lo);
        end
        n_cmp++;
        if (lines != 45) begin
            n_err++;
            $display("FAIL vblank_lines: got %0d want 45", lines);
        end
    endtask

    task automatic test_line();
        int errs = 0;
        int hs_lo = 0;
        int de_hi = 0;
        int ln = 0;
        logic signed [15:0] e_sx;
        vec_t exp_v;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) tick();
            e_sx  = 16'(-160 + i);
            exp_v = mk(e_sx, 16'sd0, (e_sx >= -16'sd144 && e_sx < -16'sd48) ? 1'b0 : 1'b1,
                       1'b1, (e_sx >= 16'sd0) ? 1'b1 : 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0);
            if (act_d() !== exp_v) errs++;
            if (bus_d.o_hs == 1'b0) hs_lo++;
            if (bus_d.o_de == 1'b1) de_hi++;
            if (bus_d.o_line == 1'b1) ln++;
        end
        n_cmp++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL line_vectors: got %0d bad cycles want 0", errs);
        end
        n_cmp++;
        if (hs_lo != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d want 96", hs_lo);
        end
        n_cmp++;
        if (de_hi != 640) begin
            n_err++;
            $display("FAIL de_width: got %0d want 640", de_hi);
        end
        n_cmp++;
        if (ln != 1) begin
            n_err++;
            $display("FAIL line_pulses: got %0d want 1", ln);
        end
        tick();
        n_cmp++;
        if (act_d() !== mk(-16'sd160, 16'sd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL line_period: got %h want %h", act_d(), mk(-16'sd160, 16'sd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_wrap_line();
        int k = 0;
        while (!(bus_d.o_sx == 16'sd639 && bus_d.o_sy == 16'sd10) && k < 10000) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != 7999) begin
            n_err++;
            $display("FAIL wrap_reach: got %0d want 7999", k);
        end
        tick();
        n_cmp++;
        if (act_d() !== mk(-16'sd160, 16'sd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL wrap_line: got %h want %h", act_d(), mk(-16'sd160, 16'sd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_midframe_reset();
        int k = 0;
        while (!(bus_d.o_sx == 16'sd100 && bus_d.o_sy == 16'sd11) && k < 1000) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != 260) begin
            n_err++;
            $display("FAIL mid_reach: got %0d want 260", k);
        end
        rst_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (act_d() !== mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL mid_reset_hold%0d: got %h want %h", i, act_d(), mk(-16'sd160, -16'sd45, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            end
        end
        test_release("mid_release");
    endtask

    task automatic test_small_frames();
        int errs = 0;
        int hs_hi = 0;
        int vs_hi = 0;
        int de_hi = 0;
        int fr = 0;
        int ln = 0;
        int pos;
        logic signed [15:0] e_sx;
        logic signed [15:0] e_sy;
        vec_t exp_v;
        rst_s = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            pos   = i % 40;
            e_sx  = 16'(-4 + (pos % 8));
            e_sy  = 16'(-3 + (pos / 8));
            exp_v = mk(e_sx, e_sy,
                       (e_sx >= -16'sd3 && e_sx < -16'sd1) ? 1'b1 : 1'b0,
                       (e_sy == -16'sd2) ? 1'b1 : 1'b0,
                       (e_sx >= 16'sd0 && e_sy >= 16'sd0) ? 1'b1 : 1'b0,
                       (pos == 0) ? 1'b1 : 1'b0,
                       ((pos % 8) == 0) ? 1'b1 : 1'b0);
            if (act_s() !== exp_v) begin
                if (errs == 0) $display("FAIL small_vec at cycle %0d: got %h want %h", i, act_s(), exp_v);
                errs++;
            end
            if (bus_s.o_hs == 1'b1) hs_hi++;
            if (bus_s.o_vs == 1'b1) vs_hi++;
            if (bus_s.o_de == 1'b1) de_hi++;
            if (bus_s.o_frame == 1'b1) fr++;
            if (bus_s.o_line == 1'b1) ln++;
        end
        n_cmp++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL small_vectors: got %0d bad cycles want 0", errs);
        end
        n_cmp++;
        if ({hs_hi, vs_hi, de_hi, fr, ln} !== {32'd20, 32'd16, 32'd16, 32'd2, 32'd10}) begin
            n_err++;
            $display("FAIL small_counts: got hs=%0d vs=%0d de=%0d frame=%0d line=%0d want 20 16 16 2 10",
                     hs_hi, vs_hi, de_hi, fr, ln);
        end
    endtask

    initial begin
        test_reset();
        test_release("release");
        test_vblank();
        test_line();
        test_wrap_line();
        test_midframe_reset();
        test_small_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
